// File: rtl/seq_011_framer_tx_if.sv
// Parallel word handshake into the 011 framer: source presents data_in/data_valid,
// framer answers with data_ready.
interface seq_011_framer_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/seq_011_framer_tx.sv
// Serial frame transmitter: 0,1,1 preamble, DATA_W payload bits MSB first,
// then GAP_BITS zero bits. Moore outputs decoded from registered state only.
module seq_011_framer_tx #(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_011_framer_tx_if.slave   bus,
    output logic                 y,
    output logic                 busy,
    output logic                 done
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE0 = 3'd1,
        PRE1 = 3'd2,
        PRE2 = 3'd3,
        DATA = 3'd4,
        GAP  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    shift_d   = bus.data_in;
                    bit_cnt_d = CNT_W'(DATA_W - 1);
                    state_d   = PRE0;
                end
            end
            PRE0: state_d = PRE1;
            PRE1: state_d = PRE2;
            PRE2: state_d = DATA;
            DATA: begin
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                // Counters saturate at zero on the final cycle instead of wrapping.
                if (bit_cnt_q == '0) begin
                    state_d   = GAP;
                    gap_cnt_d = 4'(GAP_BITS - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        y    = 1'b0;
        busy = (state_q != IDLE);
        // First GAP cycle is the only one where gap_cnt still holds its load value.
        done = (state_q == GAP) && (gap_cnt_q == 4'(GAP_BITS - 1));
        case (state_q)
            PRE1:    y = 1'b1;
            PRE2:    y = 1'b1;
            DATA:    y = shift_q[DATA_W-1];
            default: y = 1'b0;
        endcase
    end

    assign bus.data_ready = (state_q == IDLE);

endmodule

// File: tb/tb_seq_011_framer_tx.sv
// Directed bench for seq_011_framer_tx: a vector table for the default build plus
// hand-written sequences for back-to-back, mid-frame reset and a DATA_W=2/GAP_BITS=3 build.
module tb_seq_011_framer_tx;
    logic clk = 1'b0;
    logic reset;
    logic y1, busy1, done1;
    logic y2, busy2, done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_011_framer_tx_if #(.DATA_W(8)) if1 ();
    seq_011_framer_tx_if #(.DATA_W(2)) if2 ();

    seq_011_framer_tx #(.DATA_W(8), .GAP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1), .y(y1), .busy(busy1), .done(done1)
    );
    seq_011_framer_tx #(.DATA_W(2), .GAP_BITS(3)) dut2 (
        .clk(clk), .reset(reset), .bus(if2), .y(y2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic       valid;
        logic [7:0] din;
        logic       y;
        logic       rdy;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [7:0] d, logic ey, logic er, logic eb, logic ed);
        vec_t t;
        t.valid = v; t.din = d; t.y = ey; t.rdy = er; t.busy = eb; t.done = ed;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame model: r=1 is the cycle right after the accept edge.
    function automatic logic fy(logic [31:0] w, int r, int dw);
        if (r == 2 || r == 3) return 1'b1;
        if (r >= 4 && r <= 3 + dw) return w[dw - 1 - (r - 4)];
        return 1'b0;
    endfunction

    function automatic logic fbusy(int r, int dw, int gw);
        return (r >= 1) && (r <= 3 + dw + gw);
    endfunction

    function automatic logic fdone(int r, int dw);
        return (r == 4 + dw);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[$];
        int dn[$];
        logic ys[0:40];
        logic [7:0] p1, p2;
        int ndone;

        reset = 1'b1;
        if1.data_valid = 1'b0; if1.data_in = '0;
        if2.data_valid = 1'b0; if2.data_in = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        chk("rst_y1", y1, 0);      chk("rst_rdy1", if1.data_ready, 1);
        chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0);
        chk("rst_y2", y2, 0);      chk("rst_rdy2", if2.data_ready, 1);

        // 0xA5 frame
        add(1, 8'hA5, 0, 0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0);
        add(0, 8'h00, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1);
        add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0);
        // 0x3C frame with data_in=0xFF and data_valid=1 while in flight
        add(1, 8'h3C, 0, 0, 1, 0);
        add(1, 8'hFF, 1, 0, 1, 0);
        add(1, 8'hFF, 1, 0, 1, 0);
        add(1, 8'hFF, 0, 0, 1, 0);
        add(1, 8'hFF, 0, 0, 1, 0);
        add(1, 8'hFF, 1, 0, 1, 0);
        add(1, 8'hFF, 1, 0, 1, 0);
        add(1, 8'hFF, 1, 0, 1, 0);
        add(1, 8'hFF, 1, 0, 1, 0);
        add(1, 8'hFF, 0, 0, 1, 0);
        add(1, 8'hFF, 0, 0, 1, 0);
        add(0, 8'hFF, 0, 0, 1, 1);
        add(0, 8'hFF, 0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            if1.data_valid = tbl[i].valid;
            if1.data_in    = tbl[i].din;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_y", i), y1, tbl[i].y);
            chk($sformatf("vec%0d_rdy", i), if1.data_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_busy", i), busy1, tbl[i].busy);
            chk($sformatf("vec%0d_done", i), done1, tbl[i].done);
        end
        if1.data_valid = 1'b0;

        // Back-to-back with data_valid held high: 0xFF then 0x00
        if1.data_valid = 1'b1;
        if1.data_in    = 8'hFF;
        for (int k = 1; k <= 26; k++) begin
            if (if1.data_ready && if1.data_valid) acc.push_back(k);
            @(posedge clk); #1;
            if (acc.size() >= 1) if1.data_in = 8'h00;
            if (done1) dn.push_back(k);
            ys[k] = y1;
            if (k == 25) if1.data_valid = 1'b0;
        end
        chk("b2b_accepts", acc.size(), 2);
        chk("b2b_dones", dn.size(), 2);
        if (acc.size() == 2) begin
            chk("b2b_accept_spacing", acc[1] - acc[0], 13);
            for (int b = 0; b < 8; b++) begin
                p1[7 - b] = ys[acc[0] + 3 + b];
                p2[7 - b] = ys[acc[1] + 3 + b];
            end
            chk("b2b_payload1", p1, 8'hFF);
            chk("b2b_payload2", p2, 8'h00);
        end
        if (dn.size() == 2) chk("b2b_done_spacing", dn[1] - dn[0], 13);
        @(posedge clk); #1;

        // Reset during the 3rd DATA cycle of 0xA5
        if1.data_valid = 1'b1;
        if1.data_in    = 8'hA5;
        @(posedge clk); #1;
        if1.data_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_y_before", y1, 1);
        chk("mid_busy_before", busy1, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_y", y1, 0);
        chk("mid_rst_rdy", if1.data_ready, 1);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_done", done1, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        chk("mid_no_done", ndone, 0);

        // Clean 0x81 frame after the abort; data_in scrambled after accept
        if1.data_valid = 1'b1;
        if1.data_in    = 8'h81;
        for (int r = 1; r <= 14; r++) begin
            @(posedge clk); #1;
            if (r == 1) begin
                if1.data_valid = 1'b0;
                if1.data_in    = 8'h7E;
            end
            chk($sformatf("f81_r%0d_y", r), y1, fy(32'h81, r, 8));
            chk($sformatf("f81_r%0d_busy", r), busy1, fbusy(r, 8, 1));
            chk($sformatf("f81_r%0d_done", r), done1, fdone(r, 8));
        end

        // DATA_W=2, GAP_BITS=3, word 2'b10
        if2.data_valid = 1'b1;
        if2.data_in    = 2'b10;
        ndone = 0;
        for (int r = 1; r <= 10; r++) begin
            @(posedge clk); #1;
            if (r == 1) begin
                if2.data_valid = 1'b0;
                if2.data_in    = 2'b01;
            end
            if (busy2) ndone++;
            chk($sformatf("w2_r%0d_y", r), y2, fy(32'h2, r, 2));
            chk($sformatf("w2_r%0d_busy", r), busy2, fbusy(r, 2, 3));
            chk($sformatf("w2_r%0d_done", r), done2, fdone(r, 2));
            chk($sformatf("w2_r%0d_rdy", r), if2.data_ready, !fbusy(r, 2, 3));
        end
        chk("w2_busy_len", ndone, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_011_framer_tx.md
# seq_011_framer_tx

Serial frame transmitter that emits the `011` sync pattern consumed by the team's Moore `011` sequence detectors. It accepts a parallel word over a valid/ready handshake and drives it onto a single-bit serial line as a frame:
- a fixed `0,1,1` preamble;
- the data word, MSB first;
- a programmable run of `0` gap bits.

It is the source end of the serial test/link path. A downstream `011` detector uses the preamble to find frame starts.

## Interface
Parameters:
- DATA_W, default 8: payload width in bits. Legal range is 2..32.
- GAP_BITS, default 1: number of `0` bits driven after the payload. Legal range is 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset. Clock is `clk`, reset is `reset`; one clock domain; reset is asynchronous and active-high.
- data_in  input  DATA_W  payload word. Sampled only on the accept edge.
- data_valid  input  1  source has a word available.
- data_ready  output  1  block can accept a word. High only in IDLE.
- y  output  1  serial line output.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse marking frame completion.

## Operation
- Moore FSM with states IDLE, PRE0, PRE1, PRE2, DATA, GAP. All outputs decode from the registered state and registered datapath only. No input-to-output combinational path.
- Outputs per state:
  - IDLE: y=0, data_ready=1, busy=0.
  - PRE0: y=0.
  - PRE1: y=1.
  - PRE2: y=1.
  - DATA: y = shift_reg[DATA_W-1].
  - GAP: y=0.
- Accept: on a rising edge where state is IDLE and data_valid=1:
  - load shift_reg <= data_in;
  - load bit_cnt <= DATA_W-1;
  - next state is PRE0.
- IDLE with data_valid=0: remain in IDLE, y held at 0.
- PRE0 → PRE1 → PRE2 → DATA, one cycle each, unconditionally.
- DATA:
  - Each cycle, shift_reg shifts left by 1 with zero fill, and bit_cnt decrements.
  - When bit_cnt==0: next state is GAP and gap_cnt <= GAP_BITS-1.
  - DATA lasts exactly DATA_W cycles.
- GAP:
  - Each cycle, gap_cnt decrements.
  - When gap_cnt==0: next state is IDLE.
  - GAP lasts exactly GAP_BITS cycles.
- done=1 only during the first GAP cycle. It is therefore exactly one cycle wide per frame.
- Counter widths:
  - bit_cnt is $clog2(DATA_W) bits.
  - gap_cnt is 4 bits.
  - Neither counter wraps in legal operation. Any unreachable state encoding recovers to IDLE on the next clock edge.
- data_in and data_valid are ignored outside IDLE. Changing data_in after the accept edge does not affect the frame in flight.

## Timing
- Reset values, applied asynchronously while reset=1:
  - state=IDLE, y=0, data_ready=1, busy=0, done=0;
  - shift_reg=0, bit_cnt=0, gap_cnt=0.
- Reset mid-frame (any non-IDLE state): the frame is aborted immediately. No done pulse is produced. The first accept is possible on the first rising edge after reset deasserts.
- Latency: the first preamble bit (PRE0) appears on y in the cycle right after the accept edge.
- Frame duration: 3 + DATA_W + GAP_BITS cycles of busy=1.
- Back-to-back throughput, with data_valid held high: one accept every 4 + DATA_W + GAP_BITS cycles, since one IDLE cycle sits between frames. With the defaults this is every 13 cycles.
- Line behaviour:
  - Every frame begins with y=0 followed by 1,1.
  - y is 0 in IDLE and in GAP.
  - Payload bits may themselves contain `011`. Frame alignment is defined solely by the preamble position.

## Test plan
- Reset: assert reset asynchronously between clock edges → y=0, data_ready=1, busy=0, done=0 immediately, without waiting for a clock edge.
- Single frame, DATA_W=8, GAP_BITS=1, data_in=0xA5 accepted:
  - y over the next 12 cycles = 0,1,1, 1,0,1,0,0,1,0,1, 0, then 0 in IDLE;
  - done high only in cycle 12;
  - busy high for cycles 1..12.
- Back-to-back: data_valid held at 1, words 0xFF then 0x00:
  - second accept occurs exactly 13 cycles after the first;
  - second payload is eight 0s;
  - two done pulses, 13 cycles apart.
- Input stability: accept 0x3C, then drive data_in=0xFF during PRE0..DATA → transmitted payload is still 0,0,1,1,1,1,0,0.
- Reset mid-payload: accept 0xA5, assert reset during the 3rd DATA cycle → y=0 and state IDLE at once, no done pulse. The next accept, 0x81, produces a clean full frame.
- Parameter sweep: DATA_W=2, GAP_BITS=3, data_in=2'b10 → y = 0,1,1,1,0,0,0,0. busy lasts 8 cycles and done appears in cycle 6.
